button_event_ctrl: RTL and testbench

Shared-timer debounce scheduler and event queue for the board push-buttons. It synchronizes NUM_BUTTONS raw button lines and arbitrates a single settle counter among them round-robin. Each qualified state change is committed to a stable button vector and pushed as an event code into a small FIFO, which the CPU peripheral bus drains through a valid/ready handshake. It replaces one free-running debounce counter per button.

---
 rtl/button_event_ctrl_if.sv | 11 +
 rtl/button_event_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Event stream from the button scheduler to the peripheral bus: {pressed, index} with valid/ready.
interface button_event_ctrl_if #(
  parameter int IDX_W = 2
);
  logic           evt_valid;
  logic [IDX_W:0] evt_data;
  logic           evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Shared-timer round-robin button debouncer feeding an event FIFO; BTN_RELEASE_EVT_EN also queues releases.
// Latency: raw edge to btn_state/evt_valid is COUNT_MAX+4 cycles when uncontended; FIFO has no bypass.
// Backpressure: evt_ready holds the FIFO head; a commit into a full FIFO is dropped and sets sticky overflow.

module button_event_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clock_25,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [W-1:0]     head_nxt;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign full       = (count == CNT_W'(DEPTH));

  // Head is kept in its own register so the outputs come straight from flops.
  always_comb begin
    count_nxt = count;
    head_nxt  = out_dat;
    if (push && !pop)
      count_nxt = count + CNT_W'(1);
    else if (!push && pop)
      count_nxt = count - CNT_W'(1);
    if (pop) begin
      if (count > CNT_W'(1))
        head_nxt = mem[rd_ptr_nxt];
      else if (push)
        head_nxt = push_dat;
    end else if (push && count == '0) begin
      head_nxt = push_dat;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr_nxt;
      count   <= count_nxt;
      out_vld <= (count_nxt != '0);
      out_dat <= head_nxt;
    end
  end
endmodule

module button_event_ctrl #(
  parameter int          NUM_BUTTONS = 4,
  parameter int          IDX_W       = 2,
  parameter logic [31:0] COUNT_MAX   = 32'd1250000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] btn_state,
  button_event_ctrl_if.master    evt,
  output logic                   overflow,
  input  logic                   overflow_clr
);
  typedef enum logic {IDLE, SETTLE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_BUTTONS-1:0] sync_meta, sync, diff;
  logic [IDX_W-1:0]       idx, last, scan_idx;
  logic                   scan_hit;
  logic [31:0]            counter;
  logic                   commit, push_req, push, pop, drop, fifo_full;
  logic [IDX_W:0]         evt_code;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= buttons;
      sync      <= sync_meta;
    end
  end

  assign diff = sync ^ btn_state;

  // Walk from the farthest candidate back toward last+1 so the nearest mismatch wins.
  always_comb begin
    int j;
    scan_hit = 1'b0;
    scan_idx = '0;
    j        = 0;
    for (int k = NUM_BUTTONS; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_BUTTONS;
      if (diff[IDX_W'(j)]) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (scan_hit)
          state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!diff[idx]) begin
          state_nxt = IDLE;
        end else if (counter == COUNT_MAX) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= IDX_W'(NUM_BUTTONS - 1);
      counter   <= '0;
      btn_state <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        counter <= '0;
        if (scan_hit)
          idx <= scan_idx;
      end else begin
        counter <= counter + 32'd1;
      end
      if (commit) begin
        btn_state[idx] <= sync[idx];
        last           <= idx;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  assign evt_code = {sync[idx], idx};
`ifdef BTN_RELEASE_EVT_EN
  assign push_req = commit;
`else
  assign push_req = commit && sync[idx];
`endif
  assign pop  = evt.evt_valid && evt.evt_ready;
  assign push = push_req && (!fifo_full || pop);
  assign drop = push_req && fifo_full && !pop;

  button_event_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_25 (clock_25),
    .reset    (reset),
    .push     (push),
    .push_dat (evt_code),
    .pop      (pop),
    .full     (fifo_full),
    .out_vld  (evt.evt_valid),
    .out_dat  (evt.evt_data)
  );
endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with COUNT_MAX=8, four buttons; tracks BTN_RELEASE_EVT_EN.
module tb_button_event_ctrl;
  localparam int NB = 4;
  localparam int IW = 2;
`ifdef BTN_RELEASE_EVT_EN
  localparam logic REL = 1'b1;
`else
  localparam logic REL = 1'b0;
`endif

  logic          clock_25 = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [NB-1:0] btn_state;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  button_event_ctrl_if #(.IDX_W(IW)) bus ();

  button_event_ctrl #(
    .NUM_BUTTONS (NB),
    .IDX_W       (IW),
    .COUNT_MAX   (32'd8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .buttons      (buttons),
    .btn_state    (btn_state),
    .evt          (bus),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #20 clock_25 = ~clock_25;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_25);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [NB-1:0] btn;
    logic          rdy;
    int            steps;
    logic [NB-1:0] exp_btn;
    logic          exp_vld;
    logic [IW:0]   exp_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NB-1:0] b, input logic r, input int s,
                     input logic [NB-1:0] eb, input logic ev, input logic [IW:0] ed);
    vec_t v;
    v.btn = b; v.rdy = r; v.steps = s;
    v.exp_btn = eb; v.exp_vld = ev; v.exp_dat = ed;
    tbl.push_back(v);
  endtask

  logic [IW:0] exp4;
  logic [IW:0] drain_exp [4];

  initial begin
    bus.evt_ready = 1'b0;

    // Reset state, contention (0 then 3), release round, second press round.
    add(4'b0000, 0,  1, 4'b0000, 0,   3'b000);
    add(4'b1001, 0, 11, 4'b0000, 0,   3'b000);
    add(4'b1001, 0,  1, 4'b0001, 1,   3'b100);
    add(4'b1001, 0,  9, 4'b0001, 1,   3'b100);
    add(4'b1001, 0,  1, 4'b1001, 1,   3'b100);
    add(4'b1001, 1,  1, 4'b1001, 1,   3'b111);
    add(4'b1001, 1,  1, 4'b1001, 0,   3'b000);
    add(4'b0000, 0, 12, 4'b1000, REL, 3'b000);
    add(4'b0000, 0, 10, 4'b0000, REL, 3'b000);
    add(4'b0000, 1,  1, 4'b0000, REL, 3'b011);
    add(4'b0000, 1,  1, 4'b0000, 0,   3'b000);
    add(4'b1001, 0, 12, 4'b0001, 1,   3'b100);
    add(4'b1001, 0, 10, 4'b1001, 1,   3'b100);
    add(4'b1001, 1,  1, 4'b1001, 1,   3'b111);
    add(4'b1001, 1,  1, 4'b1001, 0,   3'b000);
    add(4'b0000, 1, 22, 4'b0000, REL, 3'b011);
    add(4'b0000, 1,  1, 4'b0000, 0,   3'b000);
    // Clean press of button 1 and release 20 cycles later.
    add(4'b0010, 0, 11, 4'b0000, 0,   3'b000);
    add(4'b0010, 0,  1, 4'b0010, 1,   3'b101);
    add(4'b0010, 0, 20, 4'b0010, 1,   3'b101);
    add(4'b0000, 0, 12, 4'b0000, 1,   3'b101);
    add(4'b0000, 1,  1, 4'b0000, REL, 3'b001);
    add(4'b0000, 1,  1, 4'b0000, 0,   3'b000);
    // Glitch on button 0, then a normal press proves the scheduler is idle again.
    add(4'b0001, 0,  5, 4'b0000, 0,   3'b000);
    add(4'b0000, 0, 12, 4'b0000, 0,   3'b000);
    add(4'b0100, 0, 12, 4'b0100, 1,   3'b110);
    add(4'b0000, 1, 12, 4'b0000, REL, 3'b010);
    add(4'b0000, 1,  1, 4'b0000, 0,   3'b000);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      buttons       = tbl[i].btn;
      bus.evt_ready = tbl[i].rdy;
      step(tbl[i].steps);
      chk($sformatf("row%0d btn_state", i), 32'(btn_state), 32'(tbl[i].exp_btn));
      chk($sformatf("row%0d evt_valid", i), 32'(bus.evt_valid), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld)
        chk($sformatf("row%0d evt_data", i), 32'(bus.evt_data), 32'(tbl[i].exp_dat));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'd0);
    end
    bus.evt_ready = 1'b0;

    // Overflow: four presses fill the queue, releases and a fifth press are dropped.
    do_reset();
    buttons = 4'b1111;
    step(42);
    chk("ovf fill btn_state", 32'(btn_state), 32'hF);
    chk("ovf fill overflow", 32'(overflow), 32'd0);
    chk("ovf fill head", 32'(bus.evt_data), 32'h4);
    buttons = 4'b0000;
    step(42);
    chk("ovf release btn_state", 32'(btn_state), 32'h0);
    chk("ovf release overflow", 32'(overflow), 32'(REL));
    buttons = 4'b0001;
    step(12);
    chk("ovf fifth btn_state", 32'(btn_state), 32'h1);
    chk("ovf fifth overflow", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    chk("ovf clear", 32'(overflow), 32'd0);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf drain%0d valid", i), 32'(bus.evt_valid), 32'd1);
      chk($sformatf("ovf drain%0d data", i), 32'(bus.evt_data), 32'(4 + i));
      step(1);
    end
    bus.evt_ready = 1'b0;
    chk("ovf drained valid", 32'(bus.evt_valid), 32'd0);

    // Full queue with a pop on the commit cycle: nothing is dropped.
    do_reset();
    buttons = 4'b1111;
    step(42);
    chk("full fill overflow", 32'(overflow), 32'd0);
    buttons = 4'b1110;
    if (REL) begin
      exp4 = 3'b000;
    end else begin
      exp4 = 3'b100;
      step(12);
      chk("full release btn_state", 32'(btn_state), 32'hE);
      chk("full release overflow", 32'(overflow), 32'd0);
      buttons = 4'b1111;
    end
    step(11);
    bus.evt_ready = 1'b1;
    step(1);
    bus.evt_ready = 1'b0;
    chk("full pushpop overflow", 32'(overflow), 32'd0);
    chk("full pushpop btn_state", 32'(btn_state), REL ? 32'hE : 32'hF);
    drain_exp[0] = 3'b101;
    drain_exp[1] = 3'b110;
    drain_exp[2] = 3'b111;
    drain_exp[3] = exp4;
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full drain%0d valid", i), 32'(bus.evt_valid), 32'd1);
      chk($sformatf("full drain%0d data", i), 32'(bus.evt_data), 32'(drain_exp[i]));
      step(1);
    end
    bus.evt_ready = 1'b0;
    chk("full drained valid", 32'(bus.evt_valid), 32'd0);

    // Reset while a change is settling, then re-qualification of held buttons.
    buttons = 4'b1011;
    step(8);
    reset = 1'b0;
    #1;
    chk("rst btn_state", 32'(btn_state), 32'h0);
    chk("rst evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst evt_data", 32'(bus.evt_data), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    step(1);
    reset = 1'b1;
    step(11);
    chk("requal early btn_state", 32'(btn_state), 32'h0);
    chk("requal early valid", 32'(bus.evt_valid), 32'd0);
    step(1);
    chk("requal btn_state", 32'(btn_state), 32'h1);
    chk("requal valid", 32'(bus.evt_valid), 32'd1);
    chk("requal data", 32'(bus.evt_data), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
